// File: rtl/hazard_fwd_ctrl_p.sv
// Hazard, stall, flush and operand-forwarding controller for the 5-stage RV32IMF pipeline.
// Multicycle EX ops are sequenced by a small FSM (fixed count or ready handshake with watchdog).
module hazard_fwd_ctrl_p #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NSRC    = 3,
    parameter int unsigned DIV_LAT = 8,
    parameter int unsigned WDOG    = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic                   iID_Valid,
    input  logic [NSRC*ADDR_W-1:0] iID_Rs,
    input  logic [NSRC-1:0]        iID_RsUse,
    input  logic [NSRC-1:0]        iID_RsBank,
    input  logic                   iID_Ctrl,
    input  logic                   iID_Redirect,
    input  logic                   iEX_Valid,
    input  logic                   iEX_RdWe,
    input  logic                   iEX_RdBank,
    input  logic [ADDR_W-1:0]      iEX_Rd,
    input  logic [1:0]             iEX_Class,
    input  logic                   iEX_FPReady,
    input  logic                   iMEM_RdWe,
    input  logic                   iMEM_RdBank,
    input  logic                   iMEM_IsLoad,
    input  logic [ADDR_W-1:0]      iMEM_Rd,
    input  logic                   iWB_RdWe,
    input  logic                   iWB_RdBank,
    input  logic [ADDR_W-1:0]      iWB_Rd,
    output logic                   oIF_Stall,
    output logic                   oID_Stall,
    output logic                   oEX_Stall,
    output logic                   oMEM_Stall,
    output logic                   oWB_Stall,
    output logic                   oIFID_Flush,
    output logic                   oIDEX_Flush,
    output logic [2*NSRC-1:0]      oFwd,
    output logic                   oMCBusy,
    output logic                   oTimeout,
    output logic [31:0]            oStallCnt
);

    typedef enum logic [1:0] {StIdle, StFixed, StVar} state_e;

    localparam bit              FixStall = (DIV_LAT > 1);
    localparam logic [CNT_W-1:0] FixInit = CNT_W'((DIV_LAT > 1) ? (DIV_LAT - 2) : 0);
    // Last VAR count: entry cycle plus WDOG-2 VAR cycles gives WDOG-1 stall cycles in total.
    localparam logic [CNT_W-1:0] WdogLast = CNT_W'(WDOG - 2);

    state_e            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_timeout, w_timeout_set;
    logic [31:0]       r_stall_cnt;

    logic              w_full_stall;
    logic              w_load_use;
    logic              w_bubble;
    logic              w_if_stall;
    logic              w_redirect;
    logic              w_ex_fwd_ok;
    logic [NSRC-1:0]   w_m_ex, w_m_mem, w_m_wb;
    logic [2*NSRC-1:0] w_fwd;

    // State register
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= r_timeout | w_timeout_set;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_timeout_set = 1'b0;
        case (r_state)
            StIdle: begin
                if (iEX_Valid && iEX_Class == 2'd2 && FixStall) begin
                    w_cnt_nxt   = FixInit;
                    w_state_nxt = StFixed;
                end else if (iEX_Valid && iEX_Class == 2'd3 && !iEX_FPReady) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = StVar;
                end
            end
            StFixed: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            StVar: begin
                if (iEX_FPReady) begin
                    w_state_nxt = StIdle;
                end else if (r_cnt == WdogLast) begin
                    w_timeout_set = 1'b1;
                    w_state_nxt   = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // FSM output: full pipeline stall
    always_comb begin
        w_full_stall = 1'b0;
        case (r_state)
            StIdle:  w_full_stall = iEX_Valid && ((iEX_Class == 2'd2 && FixStall) ||
                                                  (iEX_Class == 2'd3 && !iEX_FPReady));
            StFixed: w_full_stall = (r_cnt != '0);
            StVar:   w_full_stall = !iEX_FPReady && (r_cnt != WdogLast);
            default: w_full_stall = 1'b0;
        endcase
    end

    // Per-source register matches; int x0 never matches, fp f0 does
    for (genvar s = 0; s < NSRC; s++) begin : g_src
        logic [ADDR_W-1:0] w_rs;
        logic              w_ok;
        assign w_rs       = iID_Rs[s*ADDR_W +: ADDR_W];
        assign w_ok       = iID_RsUse[s] && !(!iID_RsBank[s] && w_rs == '0);
        assign w_m_ex[s]  = w_ok && iEX_Valid && iEX_RdWe && (iEX_RdBank == iID_RsBank[s]) &&
                            (iEX_Rd == w_rs);
        assign w_m_mem[s] = w_ok && iMEM_RdWe && (iMEM_RdBank == iID_RsBank[s]) &&
                            (iMEM_Rd == w_rs);
        assign w_m_wb[s]  = w_ok && iWB_RdWe && (iWB_RdBank == iID_RsBank[s]) &&
                            (iWB_Rd == w_rs);
    end

    // Multicycle results are only forwardable in the cycle they leave EX
    assign w_ex_fwd_ok = (iEX_Class == 2'd0) || (iEX_Class[1] && !w_full_stall);

    always_comb begin
        w_fwd = '0;
        for (int s = 0; s < NSRC; s++) begin
            if (w_m_ex[s] && w_ex_fwd_ok) begin
                w_fwd[2*s +: 2] = 2'd1;
            end else if (w_m_mem[s] && !iMEM_IsLoad) begin
                w_fwd[2*s +: 2] = 2'd2;
            end else if (w_m_wb[s]) begin
                w_fwd[2*s +: 2] = 2'd3;
            end
        end
    end

    assign w_load_use = ((iEX_Class == 2'd1) && (|w_m_ex)) ||
                        (iID_Ctrl && iMEM_IsLoad && (|w_m_mem));
    assign w_bubble   = w_load_use && !w_full_stall;
    assign w_if_stall = !iRST && (w_full_stall || w_bubble);
    assign w_redirect = !w_full_stall && !w_load_use && iID_Valid && iID_Ctrl && iID_Redirect;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_stall_cnt <= '0;
        end else if (w_if_stall && r_stall_cnt != 32'hFFFF_FFFF) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign oIF_Stall   = w_if_stall;
    assign oID_Stall   = w_if_stall;
    assign oEX_Stall   = !iRST && w_full_stall;
    assign oMEM_Stall  = !iRST && w_full_stall;
    assign oWB_Stall   = !iRST && w_full_stall;
    assign oIDEX_Flush = !iRST && w_bubble;
    assign oIFID_Flush = !iRST && w_redirect;
    assign oFwd        = iRST ? '0 : w_fwd;
    assign oMCBusy     = (r_state != StIdle);
    assign oTimeout    = r_timeout;
    assign oStallCnt   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_fwd_ctrl_p.sv
// Directed bench for hazard_fwd_ctrl_p: multicycle FSM, watchdog, load-use, redirect, forwarding.
module tb_hazard_fwd_ctrl_p;
    localparam int unsigned AW = 5;
    localparam int unsigned NS = 3;

    logic            iCLK = 1'b0;
    logic            iRST = 1'b1;
    logic            iID_Valid, iID_Ctrl, iID_Redirect;
    logic [NS*AW-1:0] iID_Rs;
    logic [NS-1:0]   iID_RsUse, iID_RsBank;
    logic            iEX_Valid, iEX_RdWe, iEX_RdBank, iEX_FPReady;
    logic [AW-1:0]   iEX_Rd;
    logic [1:0]      iEX_Class;
    logic            iMEM_RdWe, iMEM_RdBank, iMEM_IsLoad;
    logic [AW-1:0]   iMEM_Rd;
    logic            iWB_RdWe, iWB_RdBank;
    logic [AW-1:0]   iWB_Rd;
    logic            oIF_Stall, oID_Stall, oEX_Stall, oMEM_Stall, oWB_Stall;
    logic            oIFID_Flush, oIDEX_Flush, oMCBusy, oTimeout;
    logic [2*NS-1:0] oFwd;
    logic [31:0]     oStallCnt;

    int total = 0;
    int bad   = 0;

    hazard_fwd_ctrl_p #(
        .ADDR_W(AW), .NSRC(NS), .DIV_LAT(8), .WDOG(64), .CNT_W(7)
    ) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iID_Valid(iID_Valid), .iID_Rs(iID_Rs), .iID_RsUse(iID_RsUse),
        .iID_RsBank(iID_RsBank), .iID_Ctrl(iID_Ctrl), .iID_Redirect(iID_Redirect),
        .iEX_Valid(iEX_Valid), .iEX_RdWe(iEX_RdWe), .iEX_RdBank(iEX_RdBank),
        .iEX_Rd(iEX_Rd), .iEX_Class(iEX_Class), .iEX_FPReady(iEX_FPReady),
        .iMEM_RdWe(iMEM_RdWe), .iMEM_RdBank(iMEM_RdBank), .iMEM_IsLoad(iMEM_IsLoad),
        .iMEM_Rd(iMEM_Rd), .iWB_RdWe(iWB_RdWe), .iWB_RdBank(iWB_RdBank), .iWB_Rd(iWB_Rd),
        .oIF_Stall(oIF_Stall), .oID_Stall(oID_Stall), .oEX_Stall(oEX_Stall),
        .oMEM_Stall(oMEM_Stall), .oWB_Stall(oWB_Stall),
        .oIFID_Flush(oIFID_Flush), .oIDEX_Flush(oIDEX_Flush), .oFwd(oFwd),
        .oMCBusy(oMCBusy), .oTimeout(oTimeout), .oStallCnt(oStallCnt)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic clr();
        iID_Valid = 0; iID_Ctrl = 0; iID_Redirect = 0;
        iID_Rs = '0; iID_RsUse = '0; iID_RsBank = '0;
        iEX_Valid = 0; iEX_RdWe = 0; iEX_RdBank = 0; iEX_FPReady = 0;
        iEX_Rd = '0; iEX_Class = 2'd0;
        iMEM_RdWe = 0; iMEM_RdBank = 0; iMEM_IsLoad = 0; iMEM_Rd = '0;
        iWB_RdWe = 0; iWB_RdBank = 0; iWB_Rd = '0;
    endtask

    task automatic src(input int s, input logic [AW-1:0] a, input logic bank);
        iID_Rs[s*AW +: AW] = a;
        iID_RsUse[s]       = 1'b1;
        iID_RsBank[s]      = bank;
    endtask

    // {IF, ID, EX, MEM, WB} stalls followed by {IFID, IDEX} flushes
    function automatic logic [6:0] ctl();
        return {oIF_Stall, oID_Stall, oEX_Stall, oMEM_Stall, oWB_Stall, oIFID_Flush, oIDEX_Flush};
    endfunction

    initial begin
        clr();
        iRST = 1;
        // Reset holds everything quiet even with a class-2 op and a forwardable match present
        iEX_Valid = 1; iEX_Class = 2'd2; iEX_RdWe = 1; iEX_Rd = 5'd3; src(0, 5'd3, 0);
        #2;
        chk("rst_ctl", 32'(ctl()), 32'h00);
        chk("rst_fwd", 32'(oFwd), 32'h0);
        chk("rst_busy", 32'(oMCBusy), 32'h0);
        chk("rst_tmo", 32'(oTimeout), 32'h0);
        chk("rst_cnt", oStallCnt, 32'd0);
        tick(); clr(); iRST = 0; tick();

        // Fixed-latency op: 7 full stalls, released on the 8th cycle
        iEX_Valid = 1; iEX_Class = 2'd2;
        for (int c = 1; c <= 8; c++) begin
            #1;
            chk($sformatf("fix_ctl_c%0d", c), 32'(ctl()), (c <= 7) ? 32'h7C : 32'h00);
            if (c <= 7) chk($sformatf("fix_busy_c%0d", c), 32'(oMCBusy), (c >= 2) ? 32'h1 : 32'h0);
            tick();
        end
        iEX_Valid = 0; #1;
        chk("fix_cnt", oStallCnt, 32'd7);
        chk("fix_busy_after", 32'(oMCBusy), 32'h0);

        // Variable-latency op, ready 5 cycles after entry; EX result forwardable only on release
        iEX_Valid = 1; iEX_Class = 2'd3; iEX_RdWe = 1; iEX_Rd = 5'd9; src(0, 5'd9, 0);
        for (int c = 1; c <= 6; c++) begin
            iEX_FPReady = (c == 6);
            #1;
            chk($sformatf("var_ctl_c%0d", c), 32'(ctl()), (c <= 5) ? 32'h7C : 32'h00);
            chk($sformatf("var_fwd_c%0d", c), 32'(oFwd[1:0]), (c == 6) ? 32'h1 : 32'h0);
            tick();
        end
        clr(); #1;
        chk("var_cnt", oStallCnt, 32'd12);
        chk("var_tmo", 32'(oTimeout), 32'h0);

        // Ready never arrives: watchdog releases after 63 stall cycles
        iEX_Valid = 1; iEX_Class = 2'd3;
        for (int c = 1; c <= 64; c++) begin
            #1;
            chk($sformatf("wdg_ctl_c%0d", c), 32'(ctl()), (c <= 63) ? 32'h7C : 32'h00);
            tick();
        end
        iEX_Valid = 0; #1;
        chk("wdg_tmo", 32'(oTimeout), 32'h1);
        chk("wdg_cnt", oStallCnt, 32'd75);
        chk("wdg_busy", 32'(oMCBusy), 32'h0);
        tick(); tick(); tick();
        chk("wdg_tmo_sticky", 32'(oTimeout), 32'h1);

        // Load-use on int x7 via source 1
        clr();
        iEX_Valid = 1; iEX_Class = 2'd1; iEX_RdWe = 1; iEX_Rd = 5'd7; src(1, 5'd7, 0);
        #1;
        chk("lu_x7", 32'(ctl()), 32'h61);
        tick();
        iEX_Rd = 5'd0; src(1, 5'd0, 0); #1;
        chk("lu_x0", 32'(ctl()), 32'h00);
        tick();
        iEX_RdBank = 1; src(1, 5'd0, 1); #1;
        chk("lu_f0", 32'(ctl()), 32'h61);
        tick();

        // Forwarding priority and bank separation
        clr();
        iEX_Valid = 1; iEX_Class = 2'd0; iEX_RdWe = 1; iEX_Rd = 5'd3;
        iMEM_RdWe = 1; iMEM_Rd = 5'd3; iWB_RdWe = 1; iWB_Rd = 5'd3;
        src(0, 5'd3, 0); src(2, 5'd3, 1);
        #1;
        chk("fwd_ex", 32'(oFwd), 32'h01);
        tick();
        clr();
        iMEM_RdWe = 1; iMEM_IsLoad = 1; iMEM_Rd = 5'd4; iWB_RdWe = 1; iWB_Rd = 5'd4;
        src(0, 5'd4, 0);
        #1;
        chk("fwd_wb", 32'(oFwd), 32'h03);
        chk("fwd_wb_ctl", 32'(ctl()), 32'h00);
        tick();
        clr();
        iMEM_RdWe = 1; iMEM_Rd = 5'd5; iWB_RdWe = 1; iWB_Rd = 5'd5; src(1, 5'd5, 0);
        #1;
        chk("fwd_mem", 32'(oFwd), 32'h08);
        tick();

        // Redirect with and without concurrent load-use
        clr();
        iID_Valid = 1; iID_Ctrl = 1; iID_Redirect = 1;
        #1;
        chk("redir", 32'(ctl()), 32'h02);
        tick();
        iEX_Valid = 1; iEX_Class = 2'd1; iEX_RdWe = 1; iEX_Rd = 5'd7; src(0, 5'd7, 0);
        #1;
        chk("redir_lu", 32'(ctl()), 32'h61);
        tick();
        iEX_Valid = 0; iEX_RdWe = 0;
        iMEM_RdWe = 1; iMEM_IsLoad = 1; iMEM_Rd = 5'd7;
        #1;
        chk("redir_memload", 32'(ctl()), 32'h61);
        tick();

        // Reset during FIXED with cnt=3, then a fresh op stalls the full 7 cycles
        clr();
        iEX_Valid = 1; iEX_Class = 2'd2;
        tick(); tick(); tick(); tick();
        #1;
        chk("rfix_pre", 32'(ctl()), 32'h7C);
        iRST = 1; #1;
        chk("rfix_ctl", 32'(ctl()), 32'h00);
        chk("rfix_busy", 32'(oMCBusy), 32'h0);
        chk("rfix_tmo", 32'(oTimeout), 32'h0);
        iEX_Valid = 0;
        tick(); iRST = 0; tick(); #1;
        chk("rfix_idle", 32'(ctl()), 32'h00);
        chk("rfix_cnt0", oStallCnt, 32'd0);
        iEX_Valid = 1; iEX_Class = 2'd2;
        for (int c = 1; c <= 8; c++) begin
            #1;
            chk($sformatf("rfix2_ctl_c%0d", c), 32'(ctl()), (c <= 7) ? 32'h7C : 32'h00);
            tick();
        end
        iEX_Valid = 0; #1;
        chk("rfix2_cnt", oStallCnt, 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
